// File: rtl/cmp_op_sequencer.sv
// Operand/opcode driver and result collector for the 4-bit comparison unit.
// Single mode captures one result; sweep mode walks all 256 operand pairs and counts hits.
module cmp_op_sequencer #(
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] A_IN,
    input  logic [3:0] B_IN,
    input  logic [1:0] OP_IN,
    input  logic       MODE_IN,
    input  logic       START,
    input  logic [9:0] F,
    output logic [7:0] NUMBER,
    output logic [1:0] OP,
    output logic [9:0] RESULT,
    output logic [8:0] COUNT,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);

    // state    | meaning
    // IDLE     | waiting for a rising START
    // SETTLE   | NUMBER/OP held, settle down-counter running
    // SAMPLE   | F read: captured (single) or scored (sweep)
    // FINISH   | one-cycle DONE pulse, back to IDLE

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    state_t     state, state_nxt;
    logic       start_q;
    logic       mode_q, mode_nxt;
    logic [3:0] timer, timer_nxt;
    logic [7:0] number_nxt;
    logic [1:0] op_nxt;
    logic [9:0] result_nxt;
    logic [8:0] count_nxt;
    logic       err_nxt;

    logic       accept;
    logic       hit;
    logic       f_bad;

    assign accept = (state == S_IDLE) && START && !start_q;
    assign hit    = (OP == 2'd3) ? (F[3:0] == NUMBER[7:4]) : F[0];
    assign f_bad  = (F[9:4] != 6'd0) || ((OP != 2'd3) && (F[9:1] != 9'd0));

    assign BUSY = (state == S_SETTLE) || (state == S_SAMPLE);
    assign DONE = (state == S_FINISH);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= S_IDLE;
            start_q <= 1'b1;  // START held high through reset release must not count as an edge
            mode_q  <= 1'b0;
            timer   <= 4'd0;
            NUMBER  <= 8'd0;
            OP      <= 2'd0;
            RESULT  <= 10'd0;
            COUNT   <= 9'd0;
            ERR     <= 1'b0;
        end else begin
            state   <= state_nxt;
            start_q <= START;
            mode_q  <= mode_nxt;
            timer   <= timer_nxt;
            NUMBER  <= number_nxt;
            OP      <= op_nxt;
            RESULT  <= result_nxt;
            COUNT   <= count_nxt;
            ERR     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mode_nxt   = mode_q;
        timer_nxt  = timer;
        number_nxt = NUMBER;
        op_nxt     = OP;
        result_nxt = RESULT;
        count_nxt  = COUNT;
        err_nxt    = ERR;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    op_nxt     = OP_IN;
                    mode_nxt   = MODE_IN;
                    number_nxt = MODE_IN ? 8'h00 : {A_IN, B_IN};
                    count_nxt  = 9'd0;
                    err_nxt    = 1'b0;
                    timer_nxt  = SETTLE_LOAD;
                    state_nxt  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (timer == 4'd0) begin
                    state_nxt = S_SAMPLE;
                end else begin
                    timer_nxt = timer - 4'd1;
                end
            end
            S_SAMPLE: begin
                err_nxt = ERR | f_bad;
                if (!mode_q) begin
                    result_nxt = F;
                    state_nxt  = S_FINISH;
                end else begin
                    count_nxt = COUNT + {8'd0, hit};
                    // Last pair holds at FF so the final operand stays visible after the sweep.
                    if (NUMBER == 8'hFF) begin
                        state_nxt = S_FINISH;
                    end else begin
                        number_nxt = NUMBER + 8'd1;
                        timer_nxt  = SETTLE_LOAD;
                        state_nxt  = S_SETTLE;
                    end
                end
            end
            S_FINISH: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cmp_op_sequencer.sv
// Self-checking bench for cmp_op_sequencer: a behavioural comparator drives F,
// spec vectors from a table, hand-written corner sequences, then randomized runs.
module tb_cmp_op_sequencer;

    localparam int S     = 1;
    localparam int LIMIT = 256 * (S + 1) + 50;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] A_IN, B_IN;
    logic [1:0] OP_IN;
    logic       MODE_IN, START;
    logic [9:0] F;
    logic [7:0] NUMBER;
    logic [1:0] OP;
    logic [9:0] RESULT;
    logic [8:0] COUNT;
    logic       BUSY, DONE, ERR;

    logic       inj_en;
    logic [7:0] inj_num;
    logic [9:0] inj_val;

    int n_tests = 0;
    int n_fail  = 0;

    cmp_op_sequencer #(.SETTLE_CYC(S)) dut (
        .CLK(CLK), .RST_N(RST_N), .A_IN(A_IN), .B_IN(B_IN), .OP_IN(OP_IN),
        .MODE_IN(MODE_IN), .START(START), .F(F), .NUMBER(NUMBER), .OP(OP),
        .RESULT(RESULT), .COUNT(COUNT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Behavioural comparison unit
    function automatic logic [9:0] comp_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return {9'd0, a == b};
            2'd1:    return {9'd0, a > b};
            2'd2:    return {9'd0, a < b};
            default: return {6'd0, (a > b) ? a : b};
        endcase
    endfunction

    always_comb F = (inj_en && NUMBER == inj_num) ? inj_val : comp_f(NUMBER[7:4], NUMBER[3:0], OP);

    function automatic bit f_bad(input logic [9:0] f, input logic [1:0] op);
        return (f[9:4] != 0) || (op < 3 && f[9:1] != 0);
    endfunction

    function automatic int hit_of(input logic [9:0] f, input logic [3:0] a, input logic [1:0] op);
        if (op < 3) return int'(f[0]);
        return (f[3:0] == a) ? 1 : 0;
    endfunction

    function automatic logic [9:0] env_f(input logic [7:0] n, input logic [1:0] op);
        if (inj_en && n == inj_num) return inj_val;
        return comp_f(n[7:4], n[3:0], op);
    endfunction

    task automatic sweep_model(input logic [1:0] op, output int cnt, output bit err);
        cnt = 0;
        err = 1'b0;
        for (int n = 0; n < 256; n++) begin
            cnt += hit_of(env_f(8'(n), op), 4'(n >> 4), op);
            err |= f_bad(env_f(8'(n), op), op);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One run: accept, count BUSY cycles (bounded), confirm a single-cycle DONE.
    task automatic run(input bit mode, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                       input int glitch_at, output int busy_cnt, output bit done_ok);
        @(negedge CLK);
        A_IN = a; B_IN = b; OP_IN = op; MODE_IN = mode; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        A_IN = ~a; B_IN = ~b; OP_IN = ~op; MODE_IN = ~mode;
        busy_cnt = 0;
        while (BUSY && busy_cnt < LIMIT) begin
            busy_cnt++;
            if (glitch_at > 0) START = (busy_cnt == glitch_at) || (busy_cnt == glitch_at + 37);
            @(negedge CLK);
        end
        START = 1'b0;
        done_ok = DONE && !BUSY;
        @(negedge CLK);
        done_ok = done_ok && !DONE;
    endtask

    typedef struct {
        bit         mode;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [9:0] exp_result;
        logic [7:0] exp_number;
        logic [8:0] exp_count;
        int         exp_busy;
    } vec_t;

    vec_t vecs[7];
    int   busy_cnt;
    bit   done_ok;
    int   m_cnt;
    bit   m_err;
    logic [9:0] last_result;
    logic [9:0] ef;

    initial begin
        vecs[0] = '{1'b0, 4'h9, 4'h5, 2'd1, 10'h001, 8'h95, 9'd0,   S + 1};
        vecs[1] = '{1'b0, 4'h3, 4'hC, 2'd3, 10'h00C, 8'h3C, 9'd0,   S + 1};
        vecs[2] = '{1'b0, 4'h7, 4'h7, 2'd0, 10'h001, 8'h77, 9'd0,   S + 1};
        vecs[3] = '{1'b1, 4'h2, 4'h8, 2'd0, 10'h001, 8'hFF, 9'd16,  256 * (S + 1)};
        vecs[4] = '{1'b1, 4'h0, 4'h0, 2'd1, 10'h001, 8'hFF, 9'd120, 256 * (S + 1)};
        vecs[5] = '{1'b1, 4'hF, 4'h1, 2'd2, 10'h001, 8'hFF, 9'd120, 256 * (S + 1)};
        vecs[6] = '{1'b1, 4'h5, 4'hA, 2'd3, 10'h001, 8'hFF, 9'd136, 256 * (S + 1)};

        inj_en = 1'b0; inj_num = 8'h00; inj_val = 10'h000;
        A_IN = 4'h0; B_IN = 4'h0; OP_IN = 2'd0; MODE_IN = 1'b0;
        START = 1'b1;
        RST_N = 1'b0;
        #12;
        check("reset_outputs", {NUMBER, OP, RESULT, COUNT, BUSY, DONE, ERR}, 32'd0);

        // START high across reset release must not launch a run
        @(negedge CLK);
        RST_N = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (BUSY || DONE) busy_cnt++;
        end
        check("start_high_at_release", busy_cnt, 0);
        START = 1'b0;
        @(negedge CLK);

        foreach (vecs[i]) begin
            run(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].op, 0, busy_cnt, done_ok);
            check($sformatf("vec%0d_busy", i), busy_cnt, vecs[i].exp_busy);
            check($sformatf("vec%0d_done", i), done_ok, 1);
            check($sformatf("vec%0d_result", i), RESULT, vecs[i].exp_result);
            check($sformatf("vec%0d_number", i), NUMBER, vecs[i].exp_number);
            check($sformatf("vec%0d_op", i), OP, vecs[i].op);
            check($sformatf("vec%0d_count", i), COUNT, vecs[i].exp_count);
            check($sformatf("vec%0d_err", i), ERR, 0);
        end
        last_result = 10'h001;

        // Extra START edges mid-sweep are dropped
        run(1'b1, 4'h0, 4'h0, 2'd2, 100, busy_cnt, done_ok);
        check("glitch_busy", busy_cnt, 256 * (S + 1));
        check("glitch_done", done_ok, 1);
        check("glitch_count", COUNT, 120);
        repeat (3) @(negedge CLK);
        check("glitch_no_restart", BUSY, 0);

        // Malformed F at one sample sets sticky ERR; next start clears it
        inj_en = 1'b1; inj_num = 8'h37; inj_val = 10'h203;
        sweep_model(2'd1, m_cnt, m_err);
        run(1'b1, 4'h0, 4'h0, 2'd1, 0, busy_cnt, done_ok);
        inj_en = 1'b0;
        check("inj_err", ERR, 1);
        check("inj_count", COUNT, m_cnt);
        check("inj_model_err", ERR, m_err);
        repeat (3) @(negedge CLK);
        check("inj_err_sticky", ERR, 1);
        run(1'b0, 4'h9, 4'h5, 2'd1, 0, busy_cnt, done_ok);
        check("inj_err_cleared", ERR, 0);
        check("inj_next_result", RESULT, 10'h001);

        // Reset mid-sweep at NUMBER=40
        @(negedge CLK);
        A_IN = 4'h0; B_IN = 4'h0; OP_IN = 2'd2; MODE_IN = 1'b1; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        busy_cnt = 0;
        while (NUMBER != 8'h40 && busy_cnt < LIMIT) begin
            busy_cnt++;
            @(negedge CLK);
        end
        check("midrst_reached_40", NUMBER, 8'h40);
        RST_N = 1'b0;
        #1;
        check("midrst_outputs", {NUMBER, OP, RESULT, COUNT, BUSY, DONE, ERR}, 32'd0);
        busy_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (DONE || BUSY) busy_cnt++;
        end
        check("midrst_no_done", busy_cnt, 0);
        RST_N = 1'b1;
        run(1'b0, 4'h3, 4'hC, 2'd3, 0, busy_cnt, done_ok);
        check("midrst_rerun_busy", busy_cnt, S + 1);
        check("midrst_rerun_result", RESULT, 10'h00C);
        last_result = 10'h00C;

        // Randomized single runs, sometimes with a corrupted F
        for (int i = 0; i < 25; i++) begin
            logic [3:0] a, b;
            logic [1:0] op;
            a = 4'($urandom); b = 4'($urandom); op = 2'($urandom);
            inj_en = ($urandom_range(0, 3) == 0);
            inj_num = {a, b};
            inj_val = 10'($urandom);
            ef = inj_en ? inj_val : comp_f(a, b, op);
            run(1'b0, a, b, op, 0, busy_cnt, done_ok);
            inj_en = 1'b0;
            last_result = ef;
            check($sformatf("rnd%0d_busy", i), busy_cnt, S + 1);
            check($sformatf("rnd%0d_done", i), done_ok, 1);
            check($sformatf("rnd%0d_result", i), RESULT, ef);
            check($sformatf("rnd%0d_err", i), ERR, f_bad(ef, op));
            check($sformatf("rnd%0d_number", i), NUMBER, {a, b});
            check($sformatf("rnd%0d_count", i), COUNT, 0);
        end

        // Randomized sweeps against the counting model
        for (int i = 0; i < 3; i++) begin
            logic [1:0] op;
            op = 2'($urandom);
            inj_en = ($urandom_range(0, 1) == 0);
            inj_num = 8'($urandom);
            inj_val = 10'($urandom_range(0, 15));
            sweep_model(op, m_cnt, m_err);
            run(1'b1, 4'($urandom), 4'($urandom), op, 0, busy_cnt, done_ok);
            inj_en = 1'b0;
            check($sformatf("rsw%0d_busy", i), busy_cnt, 256 * (S + 1));
            check($sformatf("rsw%0d_count", i), COUNT, m_cnt);
            check($sformatf("rsw%0d_err", i), ERR, m_err);
            check($sformatf("rsw%0d_result_kept", i), RESULT, last_result);
            check($sformatf("rsw%0d_number", i), NUMBER, 8'hFF);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
